// File: rtl/complete_arbiter_rr_pkg.sv
// Shared types for the round-robin completion arbiter: FU completion packet,
// registered CDB lane packet and the lane-building helper.
package complete_arbiter_rr_pkg;

   localparam int XLEN          = 32;
   localparam int PR_W          = 6;
   localparam int ROB_W         = 5;
   localparam int DEF_NUM_FU    = 8;
   localparam int DEF_CDB_WIDTH = 3;

   typedef struct packed {
      logic [PR_W-1:0]  dest_pr;
      logic [XLEN-1:0]  dest_value;
      logic [ROB_W-1:0] rob_entry;
      logic             if_take_branch;
      logic [XLEN-1:0]  target_pc;
   } fu_complete_packet_t;

   typedef struct packed {
      logic             valid;
      logic [PR_W-1:0]  t;
      logic [XLEN-1:0]  value;
      logic [ROB_W-1:0] rob_entry;
      logic             precise;
      logic [XLEN-1:0]  target_pc;
   } cdb_t_packet_t;

   // Redirect PC only survives for a taken branch so idle/non-branch lanes read 0.
   function automatic cdb_t_packet_t make_lane(input fu_complete_packet_t p);
      cdb_t_packet_t c;
      c.valid     = 1'b1;
      c.t         = p.dest_pr;
      c.value     = p.dest_value;
      c.rob_entry = p.rob_entry;
      c.precise   = p.if_take_branch;
      c.target_pc = p.if_take_branch ? p.target_pc : '0;
      return c;
   endfunction

endpackage

// File: rtl/complete_arbiter_rr_if.sv
// FU-bank / CDB-ROB bundle for complete_arbiter_rr. The master modport is the
// FU bank side, the slave modport is the arbiter.
interface complete_arbiter_rr_if
   import complete_arbiter_rr_pkg::*;
#(
   parameter int NUM_FU    = DEF_NUM_FU,
   parameter int CDB_WIDTH = DEF_CDB_WIDTH
) ();

   logic                [NUM_FU-1:0]               fu_finish;
   fu_complete_packet_t [NUM_FU-1:0]               fu_c_in;
   logic                [NUM_FU-1:0]               fu_c_stall;
   logic                [CDB_WIDTH-1:0]            cdb_valid;
   logic                [CDB_WIDTH-1:0][PR_W-1:0]  cdb_t;
   logic                [CDB_WIDTH-1:0][XLEN-1:0]  wb_value;
   logic                [CDB_WIDTH-1:0]            complete_valid;
   logic                [CDB_WIDTH-1:0][ROB_W-1:0] complete_entry;
   logic                [CDB_WIDTH-1:0]            precise_state_valid;
   logic                [CDB_WIDTH-1:0][XLEN-1:0]  target_pc;

   modport master (
      output fu_finish, fu_c_in,
      input  fu_c_stall, cdb_valid, cdb_t, wb_value, complete_valid,
             complete_entry, precise_state_valid, target_pc
   );

   modport slave (
      input  fu_finish, fu_c_in,
      output fu_c_stall, cdb_valid, cdb_t, wb_value, complete_valid,
             complete_entry, precise_state_valid, target_pc
   );

endinterface

// File: rtl/complete_arbiter_rr_picker.sv
// rr_multi_picker: scans req from ptr modulo NUM_FU and grants the first
// `limit` requesters, reporting the grant vector and per-lane FU index.
module rr_multi_picker #(
   parameter int NUM_FU    = 8,
   parameter int CDB_WIDTH = 3,
   parameter int FU_IDX_W  = $clog2(NUM_FU),
   parameter int CNT_W     = $clog2(CDB_WIDTH + 1)
) (
   input  logic [NUM_FU-1:0]                  req,
   input  logic [FU_IDX_W-1:0]                ptr,
   input  logic [CNT_W-1:0]                   limit,
   output logic [NUM_FU-1:0]                  grant,
   output logic [CDB_WIDTH-1:0]               lane_vld,
   output logic [CDB_WIDTH-1:0][FU_IDX_W-1:0] lane_idx,
   output logic [FU_IDX_W-1:0]                last_idx,
   output logic                               any
);

   always_comb begin
      logic [FU_IDX_W:0]   sum;
      logic [FU_IDX_W-1:0] idx;
      int                  cnt;
      sum      = '0;
      idx      = '0;
      cnt      = 0;
      grant    = '0;
      lane_vld = '0;
      lane_idx = '0;
      last_idx = ptr;
      any      = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         // ptr < NUM_FU and k < NUM_FU, so one conditional subtract is an exact modulo
         sum = {1'b0, ptr} + (FU_IDX_W+1)'(k);
         if (sum >= (FU_IDX_W+1)'(NUM_FU))
            sum = sum - (FU_IDX_W+1)'(NUM_FU);
         idx = sum[FU_IDX_W-1:0];
         if (req[idx] && (cnt < int'(limit))) begin
            grant[idx] = 1'b1;
            for (int l = 0; l < CDB_WIDTH; l++) begin
               if (l == cnt) begin
                  lane_vld[l] = 1'b1;
                  lane_idx[l] = idx;
               end
            end
            last_idx = idx;
            any      = 1'b1;
            cnt      = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/complete_arbiter_rr.sv
// Round-robin completion arbiter: NUM_FU completions onto CDB_WIDTH registered
// CDB/ROB lanes. Optional macro COMPLETE_BRANCH_FIRST_EN gives BR_MASK FUs priority.
module complete_arbiter_rr
   import complete_arbiter_rr_pkg::*;
#(
   parameter int NUM_FU    = DEF_NUM_FU,
   parameter int CDB_WIDTH = DEF_CDB_WIDTH,
   parameter int FU_IDX_W  = $clog2(NUM_FU)
`ifdef COMPLETE_BRANCH_FIRST_EN
   ,
   parameter logic [NUM_FU-1:0] BR_MASK = NUM_FU'(8'b1000_0000)
`endif
) (
   input logic                 clock,
   input logic                 reset,
   input logic                 squash,
   complete_arbiter_rr_if.slave bus
);

   localparam int CNT_W = $clog2(CDB_WIDTH + 1);

   logic [FU_IDX_W-1:0]                rr_ptr;
   logic [NUM_FU-1:0]                  rr_req_p0;
   logic [NUM_FU-1:0]                  rr_grant_p0;
   logic [CNT_W-1:0]                   rr_limit_p0;
   logic [CDB_WIDTH-1:0]               rr_vld_p0;
   logic [CDB_WIDTH-1:0][FU_IDX_W-1:0] rr_idx_p0;
   logic [FU_IDX_W-1:0]                rr_last_p0;
   logic                               rr_any_p0;
   logic [NUM_FU-1:0]                  grant_p0;
   logic [CDB_WIDTH-1:0]               vld_p0;
   logic [CDB_WIDTH-1:0][FU_IDX_W-1:0] idx_p0;
   cdb_t_packet_t [CDB_WIDTH-1:0]      lane_p1;

   function automatic logic [FU_IDX_W-1:0] wrap_inc(input logic [FU_IDX_W-1:0] v);
      return (int'(v) == NUM_FU - 1) ? '0 : v + FU_IDX_W'(1);
   endfunction

   rr_multi_picker #(
      .NUM_FU    (NUM_FU),
      .CDB_WIDTH (CDB_WIDTH),
      .FU_IDX_W  (FU_IDX_W),
      .CNT_W     (CNT_W)
   ) u_picker (
      .req      (rr_req_p0),
      .ptr      (rr_ptr),
      .limit    (rr_limit_p0),
      .grant    (rr_grant_p0),
      .lane_vld (rr_vld_p0),
      .lane_idx (rr_idx_p0),
      .last_idx (rr_last_p0),
      .any      (rr_any_p0)
   );

`ifdef COMPLETE_BRANCH_FIRST_EN
   logic [NUM_FU-1:0]                  br_grant_p0;
   logic [CDB_WIDTH-1:0]               br_vld_p0;
   logic [CDB_WIDTH-1:0][FU_IDX_W-1:0] br_idx_p0;
   logic [CNT_W-1:0]                   br_cnt_p0;

   // Branch FUs take the lowest lanes in index order; the pointer never sees them.
   always_comb begin
      int n;
      n           = 0;
      br_grant_p0 = '0;
      br_vld_p0   = '0;
      br_idx_p0   = '0;
      for (int j = 0; j < NUM_FU; j++) begin
         if (bus.fu_finish[j] && BR_MASK[j] && (n < CDB_WIDTH)) begin
            br_grant_p0[j] = 1'b1;
            for (int l = 0; l < CDB_WIDTH; l++) begin
               if (l == n) begin
                  br_vld_p0[l] = 1'b1;
                  br_idx_p0[l] = FU_IDX_W'(j);
               end
            end
            n = n + 1;
         end
      end
      br_cnt_p0 = CNT_W'(n);
   end

   assign rr_req_p0   = bus.fu_finish & ~BR_MASK;
   assign rr_limit_p0 = CNT_W'(CDB_WIDTH) - br_cnt_p0;

   always_comb begin
      grant_p0 = br_grant_p0 | rr_grant_p0;
      vld_p0   = br_vld_p0;
      idx_p0   = br_idx_p0;
      for (int l = 0; l < CDB_WIDTH; l++) begin
         for (int m = 0; m < CDB_WIDTH; m++) begin
            if ((m + int'(br_cnt_p0) == l) && rr_vld_p0[m]) begin
               vld_p0[l] = 1'b1;
               idx_p0[l] = rr_idx_p0[m];
            end
         end
      end
   end
`else
   assign rr_req_p0   = bus.fu_finish;
   assign rr_limit_p0 = CNT_W'(CDB_WIDTH);
   assign grant_p0    = rr_grant_p0;
   assign vld_p0      = rr_vld_p0;
   assign idx_p0      = rr_idx_p0;
`endif

   // Squashed FUs flush themselves, so they are never told to hold.
   assign bus.fu_c_stall = (reset || squash) ? '0 : (bus.fu_finish & ~grant_p0);

   // p0 -> p1: granted packets captured, pointer advanced past the last rr grant
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr  <= '0;
         lane_p1 <= '0;
      end else if (squash) begin
         lane_p1 <= '0;
      end else begin
         for (int l = 0; l < CDB_WIDTH; l++)
            lane_p1[l] <= vld_p0[l] ? make_lane(bus.fu_c_in[idx_p0[l]]) : '0;
         if (rr_any_p0)
            rr_ptr <= wrap_inc(rr_last_p0);
      end
   end

   always_comb begin
      for (int l = 0; l < CDB_WIDTH; l++) begin
         bus.cdb_valid[l]           = lane_p1[l].valid;
         bus.cdb_t[l]               = lane_p1[l].t;
         bus.wb_value[l]            = lane_p1[l].value;
         bus.complete_valid[l]      = lane_p1[l].valid;
         bus.complete_entry[l]      = lane_p1[l].rob_entry;
         bus.precise_state_valid[l] = lane_p1[l].precise;
         bus.target_pc[l]           = lane_p1[l].target_pc;
      end
   end

endmodule

// File: tb/tb_complete_arbiter_rr.sv
// Bench for complete_arbiter_rr: queue-based grant model checked every cycle,
// plus directed literal expectations for the documented scenarios.
module tb_complete_arbiter_rr;
   import complete_arbiter_rr_pkg::*;

   localparam int N = 8;
   localparam int W = 3;
   localparam logic [N-1:0] BRM = 8'h80;
`ifdef COMPLETE_BRANCH_FIRST_EN
   localparam bit BR_FIRST = 1'b1;
`else
   localparam bit BR_FIRST = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;
   logic squash;
   int   n_checks = 0;
   int   n_fail   = 0;

   complete_arbiter_rr_if #(.NUM_FU(N), .CDB_WIDTH(W)) bus ();

   complete_arbiter_rr #(.NUM_FU(N), .CDB_WIDTH(W)) dut (
      .clock  (clock),
      .reset  (reset),
      .squash (squash),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_br(input int i);
      return BR_FIRST && BRM[i];
   endfunction

   // Model: lanes expected during the current cycle, and the round-robin pointer.
   int               m_ptr = 0;
   logic             m_vld [W];
   logic [PR_W-1:0]  m_t   [W];
   logic [XLEN-1:0]  m_val [W];
   logic [ROB_W-1:0] m_rob [W];
   logic             m_br  [W];
   logic [XLEN-1:0]  m_pc  [W];

   initial begin
      for (int l = 0; l < W; l++) begin
         m_vld[l] = 0; m_t[l] = 0; m_val[l] = 0; m_rob[l] = 0; m_br[l] = 0; m_pc[l] = 0;
      end
   end

   always @(negedge clock) begin
      int           g[$];
      int           last_rr;
      int           i;
      logic [N-1:0] stall;
      for (int l = 0; l < W; l++) begin
         check($sformatf("model_valid%0d", l), bus.cdb_valid[l], m_vld[l]);
         check($sformatf("model_cvalid%0d", l), bus.complete_valid[l], m_vld[l]);
         check($sformatf("model_t%0d", l), bus.cdb_t[l], m_t[l]);
         check($sformatf("model_wb%0d", l), bus.wb_value[l], m_val[l]);
         check($sformatf("model_rob%0d", l), bus.complete_entry[l], m_rob[l]);
         check($sformatf("model_psv%0d", l), bus.precise_state_valid[l], m_br[l]);
         check($sformatf("model_pc%0d", l), bus.target_pc[l], m_pc[l]);
      end
      g.delete();
      last_rr = -1;
      if (!reset && !squash) begin
         for (int j = 0; j < N; j++)
            if (bus.fu_finish[j] && is_br(j) && g.size() < W) g.push_back(j);
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (bus.fu_finish[i] && !is_br(i) && g.size() < W) begin
               g.push_back(i);
               last_rr = i;
            end
         end
      end
      stall = bus.fu_finish;
      foreach (g[q]) stall[g[q]] = 1'b0;
      if (reset || squash) stall = '0;
      check("model_stall", bus.fu_c_stall, stall);
      for (int l = 0; l < W; l++) begin
         if (l < g.size()) begin
            m_vld[l] = 1'b1;
            m_t[l]   = bus.fu_c_in[g[l]].dest_pr;
            m_val[l] = bus.fu_c_in[g[l]].dest_value;
            m_rob[l] = bus.fu_c_in[g[l]].rob_entry;
            m_br[l]  = bus.fu_c_in[g[l]].if_take_branch;
            m_pc[l]  = bus.fu_c_in[g[l]].if_take_branch ? bus.fu_c_in[g[l]].target_pc : '0;
         end else begin
            m_vld[l] = 0; m_t[l] = 0; m_val[l] = 0; m_rob[l] = 0; m_br[l] = 0; m_pc[l] = 0;
         end
      end
      if (reset) m_ptr = 0;
      else if (last_rr >= 0) m_ptr = (last_rr + 1) % N;
   end

   task automatic cyc(input logic r, input logic s, input logic [N-1:0] f, input logic tb7);
      @(posedge clock);
      #1;
      reset  = r;
      squash = s;
      bus.fu_finish = f;
      bus.fu_c_in[7].if_take_branch = tb7;
      @(negedge clock);
   endtask

   initial begin
      reset  = 1'b1;
      squash = 1'b0;
      bus.fu_finish = 8'hFF;
      for (int i = 0; i < N; i++) begin
         bus.fu_c_in[i].dest_pr        = PR_W'(10 + i);
         bus.fu_c_in[i].dest_value     = XLEN'(32'hA9 + i);
         bus.fu_c_in[i].rob_entry      = ROB_W'(i + 3);
         bus.fu_c_in[i].if_take_branch = 1'b0;
         bus.fu_c_in[i].target_pc      = XLEN'(32'h40 + i);
      end
      bus.fu_c_in[7].target_pc = 32'h80;
      @(negedge clock);
      check("rst_stall", bus.fu_c_stall, 8'h00);
      check("rst_valid", bus.cdb_valid, 3'b000);
      check("rst_cdb_t", bus.cdb_t, 18'h0);
`ifdef COMPLETE_BRANCH_FIRST_EN
      cyc(0, 0, 8'hFF, 0);
      check("bf1_stall", bus.fu_c_stall, 8'h7C);
      cyc(0, 0, 8'hFF, 0);
      check("bf1_lanes", bus.cdb_t, {6'd11, 6'd10, 6'd17});
      check("bf2_stall", bus.fu_c_stall, 8'h73);
      cyc(0, 0, 8'h00, 0);
      check("bf2_lanes", bus.cdb_t, {6'd13, 6'd12, 6'd17});
`else
      cyc(0, 0, 8'hFF, 0);
      check("ff1_stall", bus.fu_c_stall, 8'hF8);
      cyc(0, 0, 8'hFF, 0);
      check("ff1_lanes", bus.cdb_t, {6'd12, 6'd11, 6'd10});
      check("ff2_stall", bus.fu_c_stall, 8'hC7);
      cyc(0, 0, 8'hFF, 0);
      check("ff2_lanes", bus.cdb_t, {6'd15, 6'd14, 6'd13});
      check("ff3_stall", bus.fu_c_stall, 8'h3E);
      cyc(1, 0, 8'hFF, 0);
      check("midrst_lanes", bus.cdb_t, {6'd10, 6'd17, 6'd16});
      check("midrst_stall", bus.fu_c_stall, 8'h00);
      cyc(0, 0, 8'h05, 0);
      check("postrst_valid", bus.cdb_valid, 3'b000);
      check("two_req_stall", bus.fu_c_stall, 8'h00);
      cyc(0, 0, 8'h00, 0);
      check("two_lane0_t", bus.cdb_t[0], 6'd10);
      check("two_lane1_t", bus.cdb_t[1], 6'd12);
      check("two_lane1_wb", bus.wb_value[1], 32'hAB);
      check("two_lane1_rob", bus.complete_entry[1], 5'd5);
      check("two_lane2_zero", {bus.cdb_valid[2], bus.cdb_t[2], bus.wb_value[2], bus.complete_entry[2]}, '0);
      cyc(0, 0, 8'h80, 1);
      cyc(0, 0, 8'h80, 0);
      check("br_psv", bus.precise_state_valid, 3'b001);
      check("br_pc", bus.target_pc[0], 32'h80);
      check("br_t", bus.cdb_t[0], 6'd17);
      cyc(0, 1, 8'hFF, 0);
      check("sq_stall", bus.fu_c_stall, 8'h00);
      check("sq_prior_visible", bus.cdb_valid, 3'b001);
      check("nt_psv", bus.precise_state_valid, 3'b000);
      check("nt_pc", bus.target_pc[0], 32'h0);
      cyc(0, 0, 8'hFF, 0);
      check("sq_lanes_zero", bus.cdb_valid, 3'b000);
      check("sq_ptr_held", bus.fu_c_stall, 8'hF8);
      cyc(1, 1, 8'hFF, 0);
      check("rstsq_lanes", bus.cdb_t, {6'd12, 6'd11, 6'd10});
      check("rstsq_stall", bus.fu_c_stall, 8'h00);
      cyc(0, 0, 8'h00, 0);
      check("rstsq_out", bus.cdb_valid, 3'b000);
      cyc(0, 0, 8'hFF, 0);
      check("rstsq_ptr0", bus.fu_c_stall, 8'hF8);
`endif
      cyc(0, 0, 8'h00, 0);
      cyc(0, 0, 8'h00, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
